// File: rtl/fc_neuron_mac.sv
// fc_neuron_mac
//   Fully-connected neuron for the FNN accelerator layer array. It holds its own
//   weight memory and a run-time bias, both written over the shared layer/neuron
//   config bus. It accumulates one streamed input vector per result with a
//   saturating MAC, adds the bias, applies the activation and holds the result
//   until downstream accepts it.
//
//   Optional feature macro: FC_NEURON_SAT_FLAG_EN adds the sat_flag output.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cfg_layer_num, cfg_neuron_num  config target; writes need both to match
//   weight_valid, weight_value     weight write strobe / data (low DW bits)
//   bias_valid, bias_value         bias write strobe / data (low DW bits)
//   in_valid, in_ready, in_data    input sample stream
//   out_valid, out_ready, out_data activated result, held until accepted
//   sat_flag (macro only)          any saturation occurred for this result
module fc_neuron_mac #(
  parameter int LAYER_NO   = 2,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 30,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACT_MODE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cfg_layer_num,
  input  logic [31:0]           cfg_neuron_num,
  input  logic                  weight_valid,
  input  logic [31:0]           weight_value,
  input  logic                  bias_valid,
  input  logic [31:0]           bias_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef FC_NEURON_SAT_FLAG_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = $clog2(NUM_WEIGHT);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WEIGHT - 1);
  localparam logic signed [PW-1:0] ACC_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] ACC_MIN = {1'b1, {(PW-1){1'b0}}};
  localparam logic signed [PW-1:0] RES_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] RES_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {ST_LOAD, ST_DRAIN, ST_BIAS, ST_OUT} state_e;

  function automatic logic signed [PW-1:0] sext(input logic [DW-1:0] v);
    return $signed({{DW{v[DW-1]}}, v});
  endfunction

  // Two's-complement overflow happens only when both operands share a sign
  // and the truncated sum does not.
  function automatic logic add_ovf(input logic signed [PW-1:0] a,
                                   input logic signed [PW-1:0] b);
    logic signed [PW-1:0] s;
    s = a + b;
    return (a[PW-1] == b[PW-1]) && (s[PW-1] != a[PW-1]);
  endfunction

  function automatic logic signed [PW-1:0] sat_add(input logic signed [PW-1:0] a,
                                                   input logic signed [PW-1:0] b);
    if (add_ovf(a, b)) return a[PW-1] ? ACC_MIN : ACC_MAX;
    return a + b;
  endfunction

  function automatic logic [DW-1:0] activate(input logic signed [PW-1:0] a);
    logic signed [PW-1:0] sh;
    logic [DW-1:0]        r;
    sh = a >>> FRAC_BITS;
    if (sh > RES_MAX)      r = RES_MAX[DW-1:0];
    else if (sh < RES_MIN) r = RES_MIN[DW-1:0];
    else                   r = sh[DW-1:0];
    if (ACT_MODE == 1 && r[DW-1]) r = '0;
    return r;
  endfunction

`ifdef FC_NEURON_SAT_FLAG_EN
  function automatic logic res_ovf(input logic signed [PW-1:0] a);
    logic signed [PW-1:0] sh;
    sh = a >>> FRAC_BITS;
    return (sh > RES_MAX) || (sh < RES_MIN);
  endfunction
`endif

  state_e               state_q, state_d;
  logic [1:0]           drain_q, drain_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [DW-1:0]        bias_q, bias_d;
  logic signed [PW-1:0] acc_q, acc_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 prod_vld_q, prod_vld_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [DW-1:0]        x_q, x_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [DW-1:0]        mem_q [NUM_WEIGHT];

  logic                 cfg_hit;
  logic                 weight_we;
  logic                 accept;
  logic                 out_fire;
  logic signed [PW-1:0] bias_ext;

  assign cfg_hit   = (cfg_layer_num == 32'(LAYER_NO)) && (cfg_neuron_num == 32'(NEURON_NO));
  assign weight_we = weight_valid && cfg_hit;
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign bias_ext  = sext(bias_q) <<< FRAC_BITS;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_LOAD: begin
        if (accept && cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) state_d = ST_BIAS;
      end
      ST_BIAS: state_d = ST_OUT;
      ST_OUT:  if (out_fire) state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end

  // Datapath: registered memory read -> registered multiply -> accumulate.
  // The read uses the pre-edge memory contents, so a same-address write in the
  // same cycle returns the old word.
  always_comb begin
    wptr_d      = wptr_q;
    bias_d      = bias_q;
    cnt_d       = cnt_q;
    rd_vld_d    = accept;
    rdata_d     = mem_q[cnt_q];
    x_d         = accept ? in_data : x_q;
    prod_vld_d  = rd_vld_q;
    prod_d      = sext(rdata_q) * sext(x_q);
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (weight_we) wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
    if (bias_valid && cfg_hit) bias_d = bias_value[DW-1:0];
    if (accept) cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;

    if (prod_vld_q) acc_d = sat_add(acc_q, prod_q);
    if (state_q == ST_BIAS) acc_d = sat_add(acc_q, bias_ext);

    // The result is narrowed one cycle after entering OUT, which gives the
    // five-edge latency from the last accepted sample.
    if (state_q == ST_OUT && !out_valid_q) begin
      out_valid_d = 1'b1;
      out_data_d  = activate(acc_q);
    end
    if (out_fire) begin
      out_valid_d = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      drain_q     <= '0;
      cnt_q       <= '0;
      wptr_q      <= '0;
      bias_q      <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      rd_vld_q    <= 1'b0;
      prod_vld_q  <= 1'b0;
      rdata_q     <= '0;
      x_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      rd_vld_q    <= rd_vld_d;
      prod_vld_q  <= prod_vld_d;
      rdata_q     <= rdata_d;
      x_q         <= x_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Weight memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (weight_we) mem_q[wptr_q] <= weight_value[DW-1:0];
  end

`ifdef FC_NEURON_SAT_FLAG_EN
  logic sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (prod_vld_q && add_ovf(acc_q, prod_q)) sat_d = 1'b1;
    if (state_q == ST_BIAS && add_ovf(acc_q, bias_ext)) sat_d = 1'b1;
    if (state_q == ST_OUT && !out_valid_q && res_ovf(acc_q)) sat_d = 1'b1;
    if (out_fire) sat_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`endif

  if (DW < 32) begin : g_unused
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{weight_value[31:DW], bias_value[31:DW]};
  end

endmodule

// File: tb/tb_fc_neuron_mac.sv
module tb_fc_neuron_mac;
  localparam int NW = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] cfg_layer_num, cfg_neuron_num;
  logic        weight_valid, bias_valid;
  logic [31:0] weight_value, bias_value;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        in_ready_r, out_valid_r, in_ready_l, out_valid_l;
  logic [15:0] out_data_r, out_data_l;
`ifdef FC_NEURON_SAT_FLAG_EN
  logic        sat_r, sat_l;
`endif

  fc_neuron_mac #(.LAYER_NO(2), .NEURON_NO(0), .NUM_WEIGHT(NW), .DATA_WIDTH(16),
                  .FRAC_BITS(8), .ACT_MODE(1)) dut_relu (
    .clk(clk), .rst(rst), .cfg_layer_num(cfg_layer_num), .cfg_neuron_num(cfg_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r)
`ifdef FC_NEURON_SAT_FLAG_EN
    , .sat_flag(sat_r)
`endif
  );

  fc_neuron_mac #(.LAYER_NO(2), .NEURON_NO(0), .NUM_WEIGHT(NW), .DATA_WIDTH(16),
                  .FRAC_BITS(8), .ACT_MODE(0)) dut_lin (
    .clk(clk), .rst(rst), .cfg_layer_num(cfg_layer_num), .cfg_neuron_num(cfg_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l)
`ifdef FC_NEURON_SAT_FLAG_EN
    , .sat_flag(sat_l)
`endif
  );

  typedef struct packed {
    logic [15:0] relu;
    logic [15:0] lin;
    logic        sat;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  logic [15:0] m_w [NW];
  logic [15:0] m_bias;
  int          m_wptr;
  int          rdy_mode = 0;
  longint      edge_cnt = 0;
  longint      last_acc = 0;
  bit          prev_ov = 0;
  bit          prev_hs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  // Reference: plain integer arithmetic with explicit clamping.
  function automatic exp_t model_calc(input logic [15:0] xs [NW]);
    longint acc, r;
    bit     sat;
    exp_t   e;
    acc = 0;
    sat = 0;
    for (int i = 0; i < NW; i++) begin
      acc = acc + longint'($signed(m_w[i])) * longint'($signed(xs[i]));
      if (acc > 64'sd2147483647)  begin acc = 64'sd2147483647;  sat = 1; end
      if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; sat = 1; end
    end
    acc = acc + longint'($signed(m_bias)) * 256;
    if (acc > 64'sd2147483647)  begin acc = 64'sd2147483647;  sat = 1; end
    if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; sat = 1; end
    r = acc >>> 8;
    if (r > 32767)  begin r = 32767;  sat = 1; end
    if (r < -32768) begin r = -32768; sat = 1; end
    e.lin  = r[15:0];
    e.relu = (r < 0) ? 16'h0000 : r[15:0];
    e.sat  = sat;
    return e;
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Compare process: checks every cycle a result is presented.
  always @(negedge clk) begin
    bit hs;
    if (rst) begin
      prev_ov = 0;
      prev_hs = 0;
    end else begin
      if (prev_hs) begin
        chk("ready_after_accept", in_ready_r, 1);
        chk("valid_clear_after_accept", out_valid_r, 0);
      end
      if (out_valid_r) begin
        if (exp_q.size() == 0) fail_now("spurious_out_valid");
        else begin
          chk("relu_data", out_data_r, exp_q[0].relu);
          chk("lin_valid", out_valid_l, 1);
          chk("lin_data", out_data_l, exp_q[0].lin);
`ifdef FC_NEURON_SAT_FLAG_EN
          chk("relu_sat", sat_r, exp_q[0].sat);
          chk("lin_sat", sat_l, exp_q[0].sat);
`endif
        end
        chk("in_ready_while_out", in_ready_r, 0);
        if (!prev_ov) chk("latency", 32'(edge_cnt - last_acc), 5);
      end else if (prev_ov && !prev_hs) begin
        fail_now("out_valid_dropped");
      end
      hs = out_valid_r && out_ready;
      if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
      prev_ov = out_valid_r;
      prev_hs = hs;
      if (in_valid && in_ready_r) last_acc = edge_cnt + 1;
    end
  end

  // Downstream ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input bit is_bias, input int layer, input int neuron,
                           input logic [15:0] val);
    cfg_layer_num  = layer;
    cfg_neuron_num = neuron;
    weight_value   = {16'($urandom), val};
    bias_value     = {16'($urandom), val};
    weight_valid   = !is_bias;
    bias_valid     = is_bias;
    step();
    weight_valid = 1'b0;
    bias_valid   = 1'b0;
    if (layer == 2 && neuron == 0) begin
      if (is_bias) m_bias = val;
      else begin
        m_w[m_wptr] = val;
        m_wptr = (m_wptr + 1) % NW;
      end
    end
  endtask

  task automatic send_sample(input logic [15:0] d);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (in_ready_r) begin
        step();
        done = 1;
      end
    end
    if (!done) begin
      fail_now("accept_timeout");
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_vector(input logic [15:0] xs [NW], input int gap_max);
    for (int i = 0; i < NW; i++) begin
      repeat ($urandom_range(0, gap_max)) step();
      send_sample(xs[i]);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) step();
    if (exp_q.size() != 0) begin
      fail_now("result_timeout");
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    m_wptr = 0;
    m_bias = 16'h0000;
    chk("rst_out_valid", out_valid_r, 0);
    chk("rst_out_data", out_data_r, 16'h0000);
    chk("rst_in_ready", in_ready_r, 1);
  endtask

  // Pins the model against a hand-computed literal, then queues the literal.
  task automatic run_directed(input string nm, input logic [15:0] xs [NW], input exp_t lit);
    exp_t e;
    e = model_calc(xs);
    chk({nm, "_model_relu"}, e.relu, lit.relu);
    chk({nm, "_model_lin"}, e.lin, lit.lin);
    chk({nm, "_model_sat"}, e.sat, lit.sat);
    exp_q.push_back(lit);
    send_vector(xs, 2);
  endtask

  function automatic logic [15:0] rnd16();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 1536)) - 16'd768;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v1 [NW];
    logic [15:0] v2 [NW];
    logic [15:0] v3 [NW];
    logic [15:0] xs [NW];
    exp_t        e;
    v1 = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    v2 = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    v3 = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    rst = 1'b1;
    cfg_layer_num = '0; cfg_neuron_num = '0;
    weight_valid = 1'b0; bias_valid = 1'b0;
    weight_value = '0; bias_value = '0;
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < NW; i++) m_w[i] = 16'h0000;
    step();
    do_reset();

    // Basic vector with ReLU and positive bias
    for (int i = 0; i < NW; i++) cfg_write(0, 2, 0, 16'h0100);
    cfg_write(1, 2, 0, 16'h0080);
    run_directed("t1", v1, '{relu: 16'h0A80, lin: 16'h0A80, sat: 1'b0});
    wait_idle();

    // Downstream stall for 10 cycles
    rdy_mode = 2;
    step();
    step();
    run_directed("t4", v1, '{relu: 16'h0A80, lin: 16'h0A80, sat: 1'b0});
    for (int c = 0; c < 50 && !out_valid_r; c++) step();
    repeat (10) step();
    chk("t4_held_valid", out_valid_r, 1);
    rdy_mode = 0;
    wait_idle();

    // Writes addressed to another neuron / layer are ignored
    for (int i = 0; i < NW; i++) cfg_write(0, 2, 1, 16'h1234);
    cfg_write(1, 2, 1, 16'h7777);
    cfg_write(0, 3, 0, 16'h4321);
    cfg_write(1, 3, 0, 16'h0F0F);
    run_directed("t5", v1, '{relu: 16'h0A80, lin: 16'h0A80, sat: 1'b0});
    wait_idle();

    // Reset mid-vector: weights survive, bias cleared
    send_sample(16'h0100);
    send_sample(16'h0200);
    do_reset();
    cfg_write(1, 2, 0, 16'h0080);
    run_directed("t6", v1, '{relu: 16'h0A80, lin: 16'h0A80, sat: 1'b0});
    wait_idle();

    // Negative result: linear vs ReLU
    for (int i = 0; i < NW; i++) cfg_write(0, 2, 0, 16'hFF00);
    cfg_write(1, 2, 0, 16'h0000);
    run_directed("t2", v2, '{relu: 16'h0000, lin: 16'hFC00, sat: 1'b0});
    wait_idle();

    // Positive saturation through accumulate, bias and narrowing
    for (int i = 0; i < NW; i++) cfg_write(0, 2, 0, 16'h7FFF);
    cfg_write(1, 2, 0, 16'h7FFF);
    run_directed("t3", v3, '{relu: 16'h7FFF, lin: 16'h7FFF, sat: 1'b1});
    wait_idle();

    // Randomized vectors, config and backpressure
    for (int v = 0; v < 40; v++) begin
      rdy_mode = 1;
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 5)) begin
          case ($urandom_range(0, 3))
            0:       cfg_write(0, 2, 1, rnd16());
            1:       cfg_write(0, 1, 0, rnd16());
            default: cfg_write(0, 2, 0, rnd16());
          endcase
        end
        if ($urandom_range(0, 1) == 0) cfg_write(1, 2, 0, rnd16());
        if ($urandom_range(0, 3) == 0) cfg_write(1, 2, 3, rnd16());
      end
      for (int i = 0; i < NW; i++) xs[i] = rnd16();
      e = model_calc(xs);
      exp_q.push_back(e);
      send_vector(xs, 3);
    end
    wait_idle();
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
